// File: rtl/proc_pkg.sv
// Shared processor-core types and sizes used by the register file and its decode neighbours.
// Latency: none. This file holds only types and constants.
// Backpressure: none.
package proc_pkg;

   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 4;
   localparam int REG_DEPTH  = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] word_t;

endpackage : proc_pkg

// File: rtl/regfile_rd_mux.sv
// Purpose: DEPTH:1 read-select mux over the flattened register bank.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the select and the bank continuously.
//
// Ports:
//   bank_dat  in   DEPTH*DATA_W  all registers, entry i at bits [i*DATA_W +: DATA_W]
//   sel       in   ADDR_W        register index to present
//   out_dat   out  DATA_W        bank entry selected by sel
module regfile_rd_mux
   import proc_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [(2**ADDR_W)*DATA_W-1:0] bank_dat,
   input  logic [ADDR_W-1:0]             sel,
   output logic [DATA_W-1:0]             out_dat
);

   assign out_dat = bank_dat[sel*DATA_W +: DATA_W];

endmodule : regfile_rd_mux

// File: rtl/regfile_2r1w.sv
// Purpose: 16 x 32 flip-flop register file with two combinational read ports and one write port.
// Latency: reads take zero cycles. A write becomes visible right after the clock edge that takes it, with no bypass.
// Backpressure: none. There is no stall and no busy output; a write is accepted on every enabled edge.
//
// Ports:
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous active-high reset; clears every register and blocks a write in the same cycle
//   address_a     in   ADDR_W  read port A select, also the write destination
//   address_b     in   ADDR_W  read port B select
//   write_enable  in   1       write strobe
//   write_data    in   DATA_W  value written to reg[address_a]
//   data_a        out  DATA_W  reg[address_a], combinational
//   data_b        out  DATA_W  reg[address_b], combinational
module regfile_2r1w
   import proc_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address_a,
   input  logic [ADDR_W-1:0] address_b,
   input  logic              write_enable,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]       regs_q [DEPTH];
   logic [DATA_W-1:0]       regs_d [DEPTH];
   logic [DEPTH*DATA_W-1:0] bank_dat;

   // The next state differs from the current state only at the write destination.
   // The address is not examined when write_enable is low, so an undefined address
   // in an idle cycle leaves the bank untouched.
   always_comb begin
      regs_d = regs_q;
      if (write_enable) begin
         regs_d[address_a] = write_data;
      end
   end

   // Reset has priority over a write issued in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Flatten the bank once so that both read muxes share a single view of it.
   always_comb begin
      bank_dat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         bank_dat[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

   regfile_rd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_mux_a (
      .bank_dat (bank_dat),
      .sel      (address_a),
      .out_dat  (data_a)
   );

   regfile_rd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_mux_b (
      .bank_dat (bank_dat),
      .sel      (address_b),
      .out_dat  (data_b)
   );

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Purpose: self-checking bench for regfile_2r1w, combining directed cases with a random write/read mix.
// Latency: reads are compared in the same cycle as their address; writes are compared just after the edge.
// Backpressure: not applicable to this design.
module tb_regfile_2r1w;
   import proc_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   reg_addr_t address_a;
   reg_addr_t address_b;
   logic      write_enable;
   word_t     write_data;
   word_t     data_a;
   word_t     data_b;

   // Reference model: an array of 16 words that is updated only when a clock edge is taken.
   word_t model [REG_DEPTH];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   regfile_2r1w dut (
      .clk          (clk),
      .rst          (rst),
      .address_a    (address_a),
      .address_b    (address_b),
      .write_enable (write_enable),
      .write_data   (write_data),
      .data_a       (data_a),
      .data_b       (data_b)
   );

   task automatic check(input string tag, input word_t obs, input word_t exp);
      total++;
      if (obs === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle. Both ports are checked against the model before the edge, showing the
   // old contents, and again after the edge, showing the new contents, with the addresses held.
   task automatic step(input logic r, input logic we, input int a, input int b, input word_t wd,
                       input string tag);
      @(negedge clk);
      rst = r; write_enable = we; address_a = reg_addr_t'(a); address_b = reg_addr_t'(b);
      write_data = wd;
      #1;
      check({tag, "_pre_a"}, data_a, model[a]);
      check({tag, "_pre_b"}, data_b, model[b]);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < REG_DEPTH; i++) model[i] = '0;
      end else if (we) begin
         model[a] = wd;
      end
      #1;
      check({tag, "_post_a"}, data_a, model[a]);
      check({tag, "_post_b"}, data_b, model[b]);
   endtask

   // Read every register on both ports without writing and compare with the model.
   task automatic read_all(input string tag);
      for (int i = 0; i < REG_DEPTH; i++) begin
         @(negedge clk);
         rst = 1'b0; write_enable = 1'b0; address_a = reg_addr_t'(i);
         address_b = reg_addr_t'(REG_DEPTH - 1 - i); write_data = $urandom;
         #1;
         check({tag, "_a"}, data_a, model[i]);
         check({tag, "_b"}, data_b, model[REG_DEPTH - 1 - i]);
      end
   endtask

   initial begin
      int a;
      int b;

      rst = 1'b1; write_enable = 1'b0; address_a = '0; address_b = '0; write_data = '0;
      // The storage starts undefined, so the first reset is applied without comparisons.
      @(posedge clk);
      for (int i = 0; i < REG_DEPTH; i++) model[i] = '0;
      #1;
      read_all("init_zero");

      // A write issued in the same cycle as reset must be dropped.
      step(1'b0, 1'b1, 3, 3, 32'hDEADBEEF, "preload3");
      check("preload3_const", data_a, 32'hDEADBEEF);
      step(1'b1, 1'b1, 3, 0, 32'h12345678, "rst_with_we");
      check("rst_we_ignored", data_a, 32'h0);
      read_all("after_rst");

      // Basic write followed by a read on both ports.
      step(1'b0, 1'b1, 5, 5, 32'h0000_1234, "wr5");
      step(1'b0, 1'b0, 5, 5, 32'h0, "rd5");
      check("rd5_a_const", data_a, 32'h0000_1234);
      check("rd5_b_const", data_b, 32'h0000_1234);

      // Read during write: the old value before the edge, the new value after it.
      step(1'b0, 1'b1, 7, 7, 32'h11, "wr7");
      @(negedge clk);
      write_enable = 1'b1; address_a = 4'd7; address_b = 4'd7; write_data = 32'h22;
      #1;
      check("rdw_before", data_a, 32'h11);
      @(posedge clk);
      model[7] = 32'h22;
      #1;
      check("rdw_after", data_a, 32'h22);

      // Two different registers read in the same cycle.
      step(1'b0, 1'b1, 2, 2, 32'hA, "wr2");
      step(1'b0, 1'b1, 9, 9, 32'hB, "wr9");
      step(1'b0, 1'b0, 2, 9, 32'hFFFF_FFFF, "dual");
      check("dual_a_const", data_a, 32'hA);
      check("dual_b_const", data_b, 32'hB);

      // Sweep every register, including register 0 and register 15.
      for (int i = 0; i < REG_DEPTH; i++) begin
         step(1'b0, 1'b1, i, (i + 1) % REG_DEPTH, word_t'(i) * 32'h0101_0101, "sweep");
      end
      read_all("sweep_rd");
      @(negedge clk);
      write_enable = 1'b0; address_a = 4'd0; address_b = 4'd15;
      #1;
      check("sweep_r0_const", data_a, 32'h0);
      check("sweep_r15_const", data_b, 32'h0F0F_0F0F);

      // Reset in the middle of traffic, then a write to the top register.
      step(1'b1, 1'b0, 0, 15, 32'h0, "mid_rst");
      read_all("mid_rst_rd");
      step(1'b0, 1'b1, 15, 15, 32'hFFFF_FFFF, "wr15");
      check("wr15_const", data_b, 32'hFFFF_FFFF);

      // Random traffic: mostly writes, some idle cycles and occasional resets.
      for (int n = 0; n < 400; n++) begin
         a = int'($urandom_range(0, REG_DEPTH - 1));
         b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, REG_DEPTH - 1));
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), a, b, $urandom, "rand");
      end
      read_all("final_rd");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected completion before 200000");
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1);
   end

endmodule : tb_regfile_2r1w
